// File: rtl/pwm_core.sv
// pwm_core: counter-based PWM generator with prescaler, double-buffered
// period/duty/prescale settings and a run/drain FSM so that dropping the
// enable always lets the current PWM period finish.
module pwm_core #(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 8
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  period,
    input  logic [WIDTH-1:0]  duty,
    input  logic [PWIDTH-1:0] presc,
    output logic              pwm_d,
    output logic              busy,
    output logic              cycle_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [PWIDTH-1:0] pcnt;
    logic [WIDTH-1:0]  cnt;

    // Pending set: written by load, waits for a safe point to be applied.
    logic [WIDTH-1:0]  p_p, d_p;
    logic [PWIDTH-1:0] k_p;
    logic              pend;

    // Shadow set: the only settings the counters and compare ever see.
    logic [WIDTH-1:0]  p_s, d_s;
    logic [PWIDTH-1:0] k_s;

    logic tick, boundary, xfer;

    assign busy      = (state != IDLE);
    assign tick      = (pcnt == k_s);
    assign boundary  = busy && tick && (cnt == p_s);
    // Transfer uses the pending contents as they stood before any
    // same-cycle load, so a load on the boundary waits one more period.
    assign xfer      = pend && ((state == IDLE) || boundary);

    // Outputs decode registered state only; no input reaches an output.
    assign pwm_d     = busy && (cnt < d_s);
    assign cycle_end = boundary;

    // FSM next-state: drain keeps counting until the period boundary.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = boundary ? IDLE : DRAIN;
            DRAIN:   begin
                if (en)            state_nx = RUN;
                else if (boundary) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ck) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Prescaler and period counters; held at zero while idle or leaving idle.
    always_ff @(posedge ck) begin
        if (rst) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if ((state == IDLE) || (state_nx == IDLE)) begin
            pcnt <= '0;
            cnt  <= '0;
        end else begin
            if (tick) begin
                pcnt <= '0;
                cnt  <= boundary ? '0 : cnt + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Pending register set and its valid flag; last load wins.
    always_ff @(posedge ck) begin
        if (rst) begin
            p_p  <= '0;
            d_p  <= '0;
            k_p  <= '0;
            pend <= 1'b0;
        end else begin
            if (load) begin
                p_p <= period;
                d_p <= duty;
                k_p <= presc;
            end
            pend <= load || (pend && !xfer);
        end
    end

    // Shadow register set, updated only at a safe point.
    always_ff @(posedge ck) begin
        if (rst) begin
            p_s <= '1;
            d_s <= '0;
            k_s <= '0;
        end else if (xfer) begin
            p_s <= p_p;
            d_s <= d_p;
            k_s <= k_p;
        end
    end

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed stimulus for pwm_core. The stimulus thread pushes the
// expected {pwm_d, busy, cycle_end} for each clock it drives into a
// scoreboard queue; a separate monitor pops and compares on the falling edge.
module tb_pwm_core;

    logic       ck = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] period;
    logic [7:0] duty;
    logic [7:0] presc;
    logic       pwm_d;
    logic       busy;
    logic       cycle_end;

    typedef struct {
        logic  pwm;
        logic  bsy;
        logic  ce;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    pwm_core #(.WIDTH(8), .PWIDTH(8)) dut (
        .ck        (ck),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .period    (period),
        .duty      (duty),
        .presc     (presc),
        .pwm_d     (pwm_d),
        .busy      (busy),
        .cycle_end (cycle_end)
    );

    always #5 ck = ~ck;

    // Monitor: compare DUT outputs against the scoreboard mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({pwm_d, busy, cycle_end} !== {e.pwm, e.bsy, e.ce}) begin
                    fails++;
                    $display("FAIL %s: pwm_d/busy/cycle_end got %b%b%b expected %b%b%b at %0t",
                             e.nm, pwm_d, busy, cycle_end, e.pwm, e.bsy, e.ce, $time);
                end else begin
                    passes++;
                end
            end
        end
    end

    // Wait one clock and record what the outputs of that clock should be.
    task automatic clk1(input logic ep, input logic eb, input logic ec, input string nm);
        exp_t e;
        @(posedge ck);
        #1;
        e.pwm = ep;
        e.bsy = eb;
        e.ce  = ec;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Expected outputs for clock c of a running period with settings P,D,K.
    task automatic run_cyc(input int p, input int d, input int k, input int c, input string nm);
        int len;
        int deff;
        len  = (p + 1) * (k + 1);
        deff = (d > p + 1) ? p + 1 : d;
        clk1(c < deff * (k + 1), 1'b1, c == len - 1, nm);
    endtask

    // One full period; optional load (and a back-to-back second load with a
    // new duty) and en drop/raise, each held during the named clock index.
    task automatic period_run(input int p, input int d, input int k,
                              input int ld_at, input int lp, input int ld, input int lk,
                              input int ld2, input int en_off, input int en_on,
                              input string nm);
        int len;
        len = (p + 1) * (k + 1);
        for (int c = 0; c < len; c++) begin
            run_cyc(p, d, k, c, nm);
            if (c == ld_at) begin
                load   = 1'b1;
                period = 8'(lp);
                duty   = 8'(ld);
                presc  = 8'(lk);
            end else if (ld2 >= 0 && c == ld_at + 1) begin
                load = 1'b1;
                duty = 8'(ld2);
            end else begin
                load = 1'b0;
            end
            if (c == en_off) en = 1'b0;
            if (c == en_on)  en = 1'b1;
        end
    endtask

    // Watchdog: the directed run is a few hundred clocks.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", passes, checks);
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        load   = 1'b1;
        period = 8'd9;
        duty   = 8'd3;
        presc  = 8'd0;

        // Reset held with en and load high.
        repeat (3) clk1(1'b0, 1'b0, 1'b0, "reset");
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        clk1(1'b0, 1'b0, 1'b0, "post_reset");

        // Load while idle, transfer happens in idle, then start.
        load = 1'b1;
        clk1(1'b0, 1'b0, 1'b0, "idle_load");
        load = 1'b0;
        clk1(1'b0, 1'b0, 1'b0, "idle_xfer");
        en = 1'b1;

        // Basic 3 high / 7 low, period 10.
        period_run(9, 3, 0, -1, 0, 0, 0, -1, -1, -1, "basic");
        period_run(9, 3, 0, -1, 0, 0, 0, -1, -1, -1, "basic");
        // Load D=7 coincident with the boundary clock: deferred one period.
        period_run(9, 3, 0,  9, 9, 7, 0, -1, -1, -1, "basic_ldbnd");
        period_run(9, 3, 0, -1, 0, 0, 0, -1, -1, -1, "bnd_load_deferred");
        // D=7 in effect; load D=3 at cnt=5, current period keeps 7 high.
        period_run(9, 7, 0,  5, 9, 3, 0, -1, -1, -1, "dbuf_mid");
        // Back-to-back loads D=5 then D=1: last one wins.
        period_run(9, 3, 0,  2, 9, 5, 0,  1, -1, -1, "dbuf_new");
        // Switch to prescale K=1.
        period_run(9, 1, 0,  4, 9, 3, 1, -1, -1, -1, "last_load_wins");
        period_run(9, 3, 1, -1, 0, 0, 0, -1, -1, -1, "presc");
        period_run(9, 3, 1,  3, 9, 0, 0, -1, -1, -1, "presc");
        // Duty extremes: D=0 then D=P+1.
        period_run(9, 0, 0,  2, 9, 10, 0, -1, -1, -1, "duty_zero");
        period_run(9, 10, 0, -1, 0, 0, 0, -1, -1, -1, "duty_full");
        period_run(9, 10, 0, 1, 9, 3, 0, -1, -1, -1, "duty_full");

        // Drain: en drops at cnt=4, period completes, then idle.
        period_run(9, 3, 0, -1, 0, 0, 0, -1, 4, -1, "drain");
        clk1(1'b0, 1'b0, 1'b0, "drain_idle");
        clk1(1'b0, 1'b0, 1'b0, "drain_idle");

        // Restart, drop at cnt=4, raise again at cnt=7: no gap.
        en = 1'b1;
        period_run(9, 3, 0, -1, 0, 0, 0, -1, 4, 7, "reenable");
        // en low only on the boundary clock: straight to idle.
        period_run(9, 3, 0, -1, 0, 0, 0, -1, 9, -1, "stop_on_bnd");
        clk1(1'b0, 1'b0, 1'b0, "stop_idle");

        // Reset at cnt=2 with a load pending: pending is discarded.
        en = 1'b1;
        run_cyc(9, 3, 0, 0, "pre_rst");
        load = 1'b1;
        duty = 8'd9;
        run_cyc(9, 3, 0, 1, "pre_rst");
        load = 1'b0;
        run_cyc(9, 3, 0, 2, "pre_rst");
        rst = 1'b1;
        clk1(1'b0, 1'b0, 1'b0, "rst_mid");
        rst = 1'b0;
        repeat (3) clk1(1'b0, 1'b1, 1'b0, "after_rst_defaults");
        en  = 1'b0;
        rst = 1'b1;
        clk1(1'b0, 1'b0, 1'b0, "final_rst");

        @(negedge ck);
        #1;
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_sb: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
